multicycle_decoder: RTL and testbench
=====================================

// Module: multicycle_decoder
// PURPOSE
//  FSM control unit for the multicycle ARM-subset core. It replaces the single-cycle decoder.
//  Sequences FETCH/DECODE/EXECUTE/WRITEBACK over several clocks so one ALU and one memory are shared.
//  Adds a parametrised multi-cycle MUL wait, gating of all writes by a condition latched at DECODE,
//  and detection of illegal instructions.
//  Sits between the instruction register (Op/Funct/Rd/Mul, stable after FETCH) and the datapath muxes.
// PARAMETERS
//  ALUCTRL_W   3  width of ALUControl (encodings below use the low 3 bits)
//  MUL_CYCLES  4  cycles spent in MULWAIT (legal range 1..15)
// PORTS
//  clk         in   1          core clock, all state updates on rising edge
//  reset       in   1          synchronous, active-low (0 = reset)
//  Op          in   2          Instr[27:26]
//  Funct       in   6          Instr[25:20]; [5]=I, [4:1]=cmd, [0]=S (L for mem)
//  Rd          in   4          Instr[15:12]
//  Mul         in   4          Instr[7:4]; 4'b1001 marks MUL
//  CondEx      in   1          condition-pass from cond unit, valid in DECODE
//  IRWrite     out  1          load instruction register
//  AdrSrc      out  1          0=PC, 1=ALUOut as memory address
//  PCWrite     out  1          load PC from Result
//  RegW        out  1          register-file write
//  MemW        out  1          data-memory write
//  ResultSrc   out  2          00=ALUOut reg, 01=read data, 10=ALU direct
//  ALUSrcA     out  1          0=reg A, 1=PC
//  ALUSrcB     out  2          00=reg B (shifter), 01=ExtImm, 10=const 4
//  ALUControl  out  ALUCTRL_W  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL, 101 MOV
//  ImmSrc      out  2          00 8-bit DP imm, 01 12-bit mem, 10 24-bit branch
//  FlagW       out  2          [1]=update N,Z; [0]=update C,V
//  MulStart    out  1          1-cycle pulse, first cycle of MULWAIT
//  BL          out  1          link write request in BRANCH
//  Illegal     out  1          1-cycle pulse, unsupported instruction
//  State       out  4          current state encoding (debug)
// BEHAVIOUR
//  - States: 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXECR, 7 EXECI, 8 ALUWB,
//    9 BRANCH, 10 MULWAIT, 11 ILLEGAL. Encodings 12-15 go to FETCH on the next edge.
//  - reset=0 at an edge: state<=FETCH, mul_cnt<=0, cond_q<=0. While reset=0, every output is 0.
//  - Outputs not listed for a state are 0.
//  - FETCH: IRWrite, PCWrite, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10. Next state: DECODE.
//  - DECODE: ALUSrcA=1, ALUSrcB=10, ADD (PC+8); cond_q<=CondEx. Next state by Op:
//      Op=01 -> MEMADR
//      Op=10 -> BRANCH
//      Op=00, !Funct[5], cmd=0000, Mul=1001 -> MULWAIT
//      Op=00, other supported cmd -> EXECI if Funct[5], else EXECR
//      Op=11 or unsupported cmd -> ILLEGAL
//  - Supported cmds: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1101 MOV, 1010 CMP (SUB, NoWrite).
//  - MEMADR: ALUSrcB=01, ImmSrc=01, ADD. Next state: MEMRD if Funct[0], else MEMWR.
//  - MEMRD: AdrSrc=1 -> MEMWB. MEMWB: ResultSrc=01, RegW=cond_q -> FETCH.
//  - MEMWR: AdrSrc=1, MemW=cond_q -> FETCH.
//  - EXECR/EXECI: ALUSrcB=00/01, ImmSrc=00, ALUControl=decoded cmd.
//      FlagW[1]=S&cond_q; FlagW[0]=S&cond_q&(ADD|SUB|CMP). Next state: ALUWB.
//  - MULWAIT: ALUControl=100. On entry mul_cnt=MUL_CYCLES-1 and MulStart=1; decrement each cycle.
//      At mul_cnt==0: FlagW[1]=S&cond_q, then ALUWB.
//      MUL_CYCLES=1 means a single MULWAIT cycle.
//  - ALUWB: ResultSrc=00, RegW=cond_q&~NoWrite. PCWrite=RegW&(Rd==15). Next state: FETCH.
//  - BRANCH: ALUSrcA=1, ALUSrcB=01, ImmSrc=10, ADD, ResultSrc=10, PCWrite=cond_q,
//      BL=cond_q&Funct[4]. Next state: FETCH.
//  - ILLEGAL: Illegal=1, no writes -> FETCH.
//  - Latency FETCH to FETCH: DP 4, LDR 5, STR 4, B 3, MUL MUL_CYCLES+3, illegal 3.
// TESTING
//  - Reset: hold reset=0 for 2 clks -> State=0, all outputs 0. Release -> IRWrite=PCWrite=1 on the 1st cycle.
//  - ADD R1,R2,#5 (Op=00, Funct=101000, CondEx=1) -> states 0,1,7,8.
//      In EXECI ALUControl=000, FlagW=00; in ALUWB RegW=1.
//  - CMP R2,#3 (Funct=110101) -> FlagW=11 in EXECI; RegW=0 in ALUWB.
//  - LDR (Op=01, Funct[0]=1) -> 0,1,2,3,4 with RegW=1 only in MEMWB.
//      STR with CondEx=0 -> MemW stays 0.
//  - MUL (Mul=1001), MUL_CYCLES=4 -> MulStart pulses once; 4 cycles in State=10, then ALUWB.
//      Apply reset=0 on the 2nd MULWAIT cycle -> FETCH next edge, MulStart never re-pulses.
//  - Op=11 -> Illegal=1 for one cycle, then FETCH.
//      MOV PC (cmd 1101, Rd=15, CondEx=1) -> PCWrite=1 in ALUWB.

Source files
------------

// File: rtl/multicycle_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multicycle_decoder                                           |
// | Description : FSM control unit for the multicycle ARM-subset core.         |
// |               Sequences FETCH / DECODE / EXECUTE / WRITEBACK so that one   |
// |               ALU and one memory are shared.  It adds a parametrised       |
// |               multi-cycle MUL wait and gates every architectural write     |
// |               with the condition latched at DECODE.  It also flags         |
// |               unsupported instructions.                                    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// | Parameters                                                                 |
// |   ALUCTRL_W   width of ALUControl (encodings occupy the low 3 bits, >= 3)  |
// |   MUL_CYCLES  cycles spent in MULWAIT, legal range 1..15                   |
// | Ports                                                                      |
// |   clk         core clock, rising edge                                      |
// |   reset       synchronous, active-low                                      |
// |   Op          Instr[27:26]                                                 |
// |   Funct       Instr[25:20]: [5]=I, [4:1]=cmd, [0]=S (L for memory ops)     |
// |   Rd          Instr[15:12]                                                 |
// |   Mul         Instr[7:4], 4'b1001 marks MUL                                |
// |   CondEx      condition pass, valid in DECODE                              |
// |   IRWrite     load instruction register                                    |
// |   AdrSrc      memory address select (0 = PC, 1 = ALUOut)                   |
// |   PCWrite     load PC from Result                                          |
// |   RegW        register-file write                                          |
// |   MemW        data-memory write                                            |
// |   ResultSrc   00 ALUOut reg, 01 read data, 10 ALU direct                   |
// |   ALUSrcA     0 reg A, 1 PC                                                |
// |   ALUSrcB     00 reg B, 01 ExtImm, 10 constant 4                           |
// |   ALUControl  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL, 101 MOV         |
// |   ImmSrc      00 8-bit DP imm, 01 12-bit mem, 10 24-bit branch             |
// |   FlagW       [1] update N,Z  [0] update C,V                               |
// |   MulStart    one-cycle pulse on the first MULWAIT cycle                   |
// |   BL          link write request in BRANCH                                 |
// |   Illegal     one-cycle pulse for an unsupported instruction               |
// |   State       current state encoding (debug)                               |
// +----------------------------------------------------------------------------+
module multicycle_decoder #(
  parameter int ALUCTRL_W  = 3,
  parameter int MUL_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic [3:0]           Mul,
  input  logic                 CondEx,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic                 PCWrite,
  output logic                 RegW,
  output logic                 MemW,
  output logic [1:0]           ResultSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           FlagW,
  output logic                 MulStart,
  output logic                 BL,
  output logic                 Illegal,
  output logic [3:0]           State
);

  // State encodings (visible on the State debug port)
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECR   = 4'd6;
  localparam logic [3:0] S_EXECI   = 4'd7;
  localparam logic [3:0] S_ALUWB   = 4'd8;
  localparam logic [3:0] S_BRANCH  = 4'd9;
  localparam logic [3:0] S_MULWAIT = 4'd10;
  localparam logic [3:0] S_ILLEGAL = 4'd11;

  // Data-processing cmd field values
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  // ALU operation encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;
  localparam logic [2:0] ALU_MOV = 3'b101;

  // First value of the MULWAIT down-counter; the wait ends when it reaches 0
  localparam logic [3:0] MUL_INIT = 4'(MUL_CYCLES - 1);

  // Registered state
  logic [3:0] r_state;
  logic [3:0] r_mul_cnt;
  logic       r_cond_q;

  // Instruction field aliases
  logic [3:0] w_cmd;
  logic       w_s;
  logic       w_is_mul;

  // Data-processing decode
  logic       w_cmd_ok;
  logic [2:0] w_alu_dp;
  logic       w_arith;
  logic       w_nowrite;

  logic [3:0] w_next;

  // Unregistered control outputs before the reset gate
  logic       w_irwrite;
  logic       w_adrsrc;
  logic       w_pcwrite;
  logic       w_regw;
  logic       w_memw;
  logic [1:0] w_resultsrc;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic [2:0] w_alu;
  logic [1:0] w_immsrc;
  logic [1:0] w_flagw;
  logic       w_mulstart;
  logic       w_bl;
  logic       w_illegal;
  logic [3:0] w_state;

  assign w_cmd = Funct[4:1];
  assign w_s   = Funct[0];

  // MUL shares the AND cmd slot; it is told apart by the register-form
  // encoding together with Instr[7:4] = 1001.
  assign w_is_mul = (Op == 2'b00) && !Funct[5] && (w_cmd == CMD_AND) &&
                    (Mul == 4'b1001);

  always_comb begin
    w_cmd_ok  = 1'b0;
    w_alu_dp  = ALU_ADD;
    w_arith   = 1'b0;
    w_nowrite = 1'b0;
    case (w_cmd)
      CMD_ADD: begin w_cmd_ok = 1'b1; w_alu_dp = ALU_ADD; w_arith = 1'b1; end
      CMD_SUB: begin w_cmd_ok = 1'b1; w_alu_dp = ALU_SUB; w_arith = 1'b1; end
      CMD_AND: begin w_cmd_ok = 1'b1; w_alu_dp = ALU_AND; end
      CMD_ORR: begin w_cmd_ok = 1'b1; w_alu_dp = ALU_ORR; end
      CMD_MOV: begin w_cmd_ok = 1'b1; w_alu_dp = ALU_MOV; end
      // CMP is a SUB that only updates flags
      CMD_CMP: begin
        w_cmd_ok  = 1'b1;
        w_alu_dp  = ALU_SUB;
        w_arith   = 1'b1;
        w_nowrite = 1'b1;
      end
      default: begin
        w_cmd_ok  = 1'b0;
        w_alu_dp  = ALU_ADD;
      end
    endcase
  end

  // Next-state logic
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          2'b00: begin
            if (w_is_mul)
              w_next = S_MULWAIT;
            else if (w_cmd_ok)
              w_next = Funct[5] ? S_EXECI : S_EXECR;
            else
              w_next = S_ILLEGAL;
          end
          default: w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:  w_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = S_MEMWB;
      S_MEMWB:   w_next = S_FETCH;
      S_MEMWR:   w_next = S_FETCH;
      S_EXECR:   w_next = S_ALUWB;
      S_EXECI:   w_next = S_ALUWB;
      S_MULWAIT: w_next = (r_mul_cnt == 4'd0) ? S_ALUWB : S_MULWAIT;
      S_ALUWB:   w_next = S_FETCH;
      S_BRANCH:  w_next = S_FETCH;
      S_ILLEGAL: w_next = S_FETCH;
      default:   w_next = S_FETCH;   // unused encodings recover to FETCH
    endcase
  end

  // State, MUL counter and latched condition
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_mul_cnt <= 4'd0;
      r_cond_q  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE)
        r_cond_q <= CondEx;
      if ((r_state == S_DECODE) && (w_next == S_MULWAIT))
        r_mul_cnt <= MUL_INIT;
      else if ((r_state == S_MULWAIT) && (r_mul_cnt != 4'd0))
        r_mul_cnt <= r_mul_cnt - 4'd1;
    end
  end

  // Output decode
  always_comb begin
    w_irwrite   = 1'b0;
    w_adrsrc    = 1'b0;
    w_pcwrite   = 1'b0;
    w_regw      = 1'b0;
    w_memw      = 1'b0;
    w_resultsrc = 2'b00;
    w_alusrca   = 1'b0;
    w_alusrcb   = 2'b00;
    w_alu       = ALU_ADD;
    w_immsrc    = 2'b00;
    w_flagw     = 2'b00;
    w_mulstart  = 1'b0;
    w_bl        = 1'b0;
    w_illegal   = 1'b0;
    w_state     = r_state;

    case (r_state)
      S_FETCH: begin
        // PC <= PC + 4 straight from the ALU while the IR loads
        w_irwrite   = 1'b1;
        w_pcwrite   = 1'b1;
        w_alusrca   = 1'b1;
        w_alusrcb   = 2'b10;
        w_resultsrc = 2'b10;
      end
      S_DECODE: begin
        // Forms PC + 8 for reads of R15
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      S_MEMADR: begin
        w_alusrcb = 2'b01;
        w_immsrc  = 2'b01;
      end
      S_MEMRD: begin
        w_adrsrc = 1'b1;
      end
      S_MEMWB: begin
        w_resultsrc = 2'b01;
        w_regw      = r_cond_q;
      end
      S_MEMWR: begin
        w_adrsrc = 1'b1;
        w_memw   = r_cond_q;
      end
      S_EXECR, S_EXECI: begin
        w_alusrcb  = (r_state == S_EXECI) ? 2'b01 : 2'b00;
        w_alu      = w_alu_dp;
        w_flagw[1] = w_s & r_cond_q;
        w_flagw[0] = w_s & r_cond_q & w_arith;
      end
      S_MULWAIT: begin
        w_alu = ALU_MUL;
        // The counter only moves down, so holding its initial value
        // identifies the first MULWAIT cycle (also when MUL_CYCLES = 1).
        w_mulstart = (r_mul_cnt == MUL_INIT);
        w_flagw[1] = (r_mul_cnt == 4'd0) & w_s & r_cond_q;
      end
      S_ALUWB: begin
        w_resultsrc = 2'b00;
        w_regw      = r_cond_q & ~w_nowrite;
        // A register write to R15 is a jump
        w_pcwrite   = r_cond_q & ~w_nowrite & (Rd == 4'd15);
      end
      S_BRANCH: begin
        w_alusrca   = 1'b1;
        w_alusrcb   = 2'b01;
        w_immsrc    = 2'b10;
        w_resultsrc = 2'b10;
        w_pcwrite   = r_cond_q;
        w_bl        = r_cond_q & Funct[4];
      end
      S_ILLEGAL: begin
        w_illegal = 1'b1;
      end
      default: begin
        w_illegal = 1'b0;
      end
    endcase

    // Reset is applied combinationally so every output is already quiet
    // in the cycle reset is asserted, before the state register reacts.
    if (!reset) begin
      w_irwrite   = 1'b0;
      w_adrsrc    = 1'b0;
      w_pcwrite   = 1'b0;
      w_regw      = 1'b0;
      w_memw      = 1'b0;
      w_resultsrc = 2'b00;
      w_alusrca   = 1'b0;
      w_alusrcb   = 2'b00;
      w_alu       = 3'b000;
      w_immsrc    = 2'b00;
      w_flagw     = 2'b00;
      w_mulstart  = 1'b0;
      w_bl        = 1'b0;
      w_illegal   = 1'b0;
      w_state     = 4'd0;
    end
  end

  assign IRWrite   = w_irwrite;
  assign AdrSrc    = w_adrsrc;
  assign PCWrite   = w_pcwrite;
  assign RegW      = w_regw;
  assign MemW      = w_memw;
  assign ResultSrc = w_resultsrc;
  assign ALUSrcA   = w_alusrca;
  assign ALUSrcB   = w_alusrcb;
  assign ImmSrc    = w_immsrc;
  assign FlagW     = w_flagw;
  assign MulStart  = w_mulstart;
  assign BL        = w_bl;
  assign Illegal   = w_illegal;
  assign State     = w_state;

  // Wider ALUControl buses carry the 3-bit encoding zero-extended
  generate
    if (ALUCTRL_W > 3) begin : g_alu_pad
      assign ALUControl = {{(ALUCTRL_W-3){1'b0}}, w_alu};
    end else begin : g_alu_exact
      assign ALUControl = w_alu[ALUCTRL_W-1:0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multicycle_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_multicycle_decoder                                        |
// | Description : Self-checking bench for multicycle_decoder.  Each            |
// |               instruction is expanded by a reference model into the list  |
// |               of control words expected on every cycle from FETCH to the   |
// |               last cycle before the next FETCH.                            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_multicycle_decoder;

  localparam int MUL_CYCLES = 4;
  localparam int ALUCTRL_W  = 3;

  logic                 clk;
  logic                 reset;
  logic [1:0]           Op;
  logic [5:0]           Funct;
  logic [3:0]           Rd;
  logic [3:0]           Mul;
  logic                 CondEx;
  logic                 IRWrite;
  logic                 AdrSrc;
  logic                 PCWrite;
  logic                 RegW;
  logic                 MemW;
  logic [1:0]           ResultSrc;
  logic                 ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic [1:0]           ImmSrc;
  logic [1:0]           FlagW;
  logic                 MulStart;
  logic                 BL;
  logic                 Illegal;
  logic [3:0]           State;

  // One cycle's worth of control outputs
  typedef struct packed {
    logic       irw;
    logic       adr;
    logic       pcw;
    logic       regw;
    logic       memw;
    logic [1:0] rs;
    logic       asa;
    logic [1:0] asb;
    logic [2:0] alu;
    logic [1:0] imm;
    logic [1:0] fw;
    logic       ms;
    logic       bl;
    logic       ill;
    logic [3:0] st;
  } vec_t;

  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  multicycle_decoder #(
    .ALUCTRL_W (ALUCTRL_W),
    .MUL_CYCLES(MUL_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Funct     (Funct),
    .Rd        (Rd),
    .Mul       (Mul),
    .CondEx    (CondEx),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .PCWrite   (PCWrite),
    .RegW      (RegW),
    .MemW      (MemW),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUControl(ALUControl),
    .ImmSrc    (ImmSrc),
    .FlagW     (FlagW),
    .MulStart  (MulStart),
    .BL        (BL),
    .Illegal   (Illegal),
    .State     (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic vec_t observed();
    vec_t v;
    v.irw  = IRWrite;
    v.adr  = AdrSrc;
    v.pcw  = PCWrite;
    v.regw = RegW;
    v.memw = MemW;
    v.rs   = ResultSrc;
    v.asa  = ALUSrcA;
    v.asb  = ALUSrcB;
    v.alu  = ALUControl[2:0];
    v.imm  = ImmSrc;
    v.fw   = FlagW;
    v.ms   = MulStart;
    v.bl   = BL;
    v.ill  = Illegal;
    v.st   = State;
    return v;
  endfunction

  task automatic check(input string tag, input vec_t got, input vec_t expv);
    n_checks++;
    if (got === expv)
      n_pass++;
    else
      $display("FAIL %s: got %h required %h", tag, got, expv);
  endtask

  // Reference model: the control-word sequence of one instruction, built
  // straight from the instruction class and its documented per-phase controls.
  task automatic build(input logic [1:0] op, input logic [5:0] f,
                       input logic [3:0] rd, input logic [3:0] mul,
                       input logic cond);
    vec_t       e;
    logic [3:0] cmd;
    logic       s;
    bit         ok, arith, nowr, do_wb;
    logic [2:0] code;
    cmd   = f[4:1];
    s     = f[0];
    ok    = 1'b1;
    arith = 1'b0;
    nowr  = 1'b0;
    do_wb = 1'b0;
    code  = 3'b000;
    case (cmd)
      4'b0100: begin code = 3'b000; arith = 1'b1; end
      4'b0010: begin code = 3'b001; arith = 1'b1; end
      4'b0000: code = 3'b010;
      4'b1100: code = 3'b011;
      4'b1101: code = 3'b101;
      4'b1010: begin code = 3'b001; arith = 1'b1; nowr = 1'b1; end
      default: ok = 1'b0;
    endcase
    exp_q.delete();

    e = '0; e.irw = 1; e.pcw = 1; e.asa = 1; e.asb = 2'b10; e.rs = 2'b10;
    e.st = 4'd0; exp_q.push_back(e);
    e = '0; e.asa = 1; e.asb = 2'b10; e.st = 4'd1; exp_q.push_back(e);

    if (op == 2'b01) begin
      e = '0; e.asb = 2'b01; e.imm = 2'b01; e.st = 4'd2; exp_q.push_back(e);
      if (f[0]) begin
        e = '0; e.adr = 1; e.st = 4'd3; exp_q.push_back(e);
        e = '0; e.rs = 2'b01; e.regw = cond; e.st = 4'd4; exp_q.push_back(e);
      end else begin
        e = '0; e.adr = 1; e.memw = cond; e.st = 4'd5; exp_q.push_back(e);
      end
    end else if (op == 2'b10) begin
      e = '0; e.asa = 1; e.asb = 2'b01; e.imm = 2'b10; e.rs = 2'b10;
      e.pcw = cond; e.bl = cond & f[4]; e.st = 4'd9; exp_q.push_back(e);
    end else if (op == 2'b00 && !f[5] && cmd == 4'b0000 && mul == 4'b1001) begin
      for (int k = 0; k < MUL_CYCLES; k++) begin
        e = '0; e.alu = 3'b100; e.st = 4'd10;
        e.ms = (k == 0);
        e.fw = {(k == MUL_CYCLES - 1) & s & cond, 1'b0};
        exp_q.push_back(e);
      end
      do_wb = 1'b1;
    end else if (op == 2'b00 && ok) begin
      e = '0; e.asb = f[5] ? 2'b01 : 2'b00; e.alu = code;
      e.fw = {s & cond, s & cond & arith};
      e.st = f[5] ? 4'd7 : 4'd6; exp_q.push_back(e);
      do_wb = 1'b1;
    end else begin
      e = '0; e.ill = 1; e.st = 4'd11; exp_q.push_back(e);
    end

    if (do_wb) begin
      e = '0; e.regw = cond & !nowr; e.pcw = cond & !nowr & (rd == 4'd15);
      e.st = 4'd8; exp_q.push_back(e);
    end
  endtask

  // Drives one instruction from FETCH and checks every cycle.  CondEx carries
  // the real condition only in DECODE and noise elsewhere.  When abort_at
  // names a cycle, reset is pulled low in it and the instruction stops there.
  task automatic run_instr(input string name, input logic [1:0] op,
                           input logic [5:0] f, input logic [3:0] rd,
                           input logic [3:0] mul, input logic cond,
                           input int abort_at);
    build(op, f, rd, mul, cond);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk);
      #1;
      Op     = op;
      Funct  = f;
      Rd     = rd;
      Mul    = mul;
      CondEx = (i == 1) ? cond : 1'($urandom);
      if (i == abort_at) begin
        reset = 1'b0;
        #1;
        check($sformatf("%s_rst_c%0d", name, i), observed(), vec_t'('0));
        return;
      end
      reset = 1'b1;
      #1;
      check($sformatf("%s_c%0d", name, i), observed(), exp_q[i]);
    end
  endtask

  initial begin
    reset  = 1'b0;
    Op     = 2'b00;
    Funct  = 6'b0;
    Rd     = 4'd0;
    Mul    = 4'd0;
    CondEx = 1'b0;

    // Held in reset for two clocks: everything quiet
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #2;
      check($sformatf("reset_%0d", i), observed(), vec_t'('0));
    end

    run_instr("add_imm",  2'b00, 6'b101000, 4'd1,  4'd0,    1'b1, -1);
    run_instr("cmp_imm",  2'b00, 6'b110101, 4'd0,  4'd0,    1'b1, -1);
    run_instr("ldr",      2'b01, 6'b011001, 4'd3,  4'd0,    1'b1, -1);
    run_instr("str_nc",   2'b01, 6'b011000, 4'd3,  4'd0,    1'b0, -1);
    run_instr("mul_s",    2'b00, 6'b000001, 4'd4,  4'b1001, 1'b1, -1);
    run_instr("op11",     2'b11, 6'b000000, 4'd0,  4'd0,    1'b1, -1);
    run_instr("mov_pc",   2'b00, 6'b111010, 4'd15, 4'd0,    1'b1, -1);
    run_instr("bl",       2'b10, 6'b010000, 4'd0,  4'd0,    1'b1, -1);
    run_instr("b_nc",     2'b10, 6'b010000, 4'd0,  4'd0,    1'b0, -1);
    run_instr("adds_r",   2'b00, 6'b001001, 4'd2,  4'd0,    1'b1, -1);
    run_instr("bad_cmd",  2'b00, 6'b001110, 4'd2,  4'd0,    1'b1, -1);

    // Reset in the second MULWAIT cycle, then a fresh instruction from FETCH
    run_instr("mul_abort", 2'b00, 6'b000000, 4'd5, 4'b1001, 1'b1, 3);
    run_instr("after_rst", 2'b00, 6'b001000, 4'd6, 4'b1001, 1'b1, -1);

    // Randomised instruction stream; MUL encodings are made common
    for (int n = 0; n < 300; n++) begin
      logic [1:0] op;
      logic [5:0] f;
      logic [3:0] rd, mul;
      logic       cond;
      op   = 2'($urandom_range(0, 3));
      f    = 6'($urandom);
      rd   = 4'($urandom);
      mul  = ($urandom_range(0, 1) == 1) ? 4'b1001 : 4'($urandom);
      cond = 1'($urandom);
      if (op == 2'b00 && $urandom_range(0, 3) == 0) f[4:1] = 4'b0000;
      run_instr($sformatf("rnd%0d", n), op, f, rd, mul, cond, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
